count_seq_ctrl: RTL and testbench
=================================

Name: count_seq_ctrl

Overview:
Command-driven sequencer for an enable-gated 4-bit counter with terminal-count output (clk/clr/enable/count/tc datapath). It clears the counter, then issues prescaled enable pulses. It tracks completed passes (wraps) and supports pause, abort, one-shot of N passes, and continuous mode. The counter sits outside this block; the bench wires cnt_en, cnt_clr and cnt_tc to it.

Parameters:
DIV, 10, prescale ratio: one cnt_en pulse per DIV clocks in RUN; legal range >= 1; DIV=1 gives continuous enable
RW, 4, width of reps and pass_cnt

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
start  in  1  one-cycle start request; sampled only in IDLE
stop  in  1  abort request; level, highest priority
pause  in  1  level; while high in RUN/HOLD, counting is frozen
reps  in  RW  pass count, latched on accepted start; 0 = continuous
cnt_tc  in  1  counter terminal-count flag (count == max)
cnt_en  out  1  counter enable (Mealy)
cnt_clr  out  1  counter synchronous clear (Mealy)
busy  out  1  high in CLEAR/RUN/HOLD
paused  out  1  high in HOLD
done  out  1  one-cycle pulse on completion of the final pass
pass_cnt  out  RW  completed passes since last start

Behaviour:
- States: IDLE, CLEAR, RUN, HOLD, DONE. All outputs are registered except cnt_en and cnt_clr.
- Reset (clr=1 at an edge): go to IDLE. Prescaler=0, reps_q=0, pass_cnt=0, busy=0, paused=0, done=0.
- cnt_clr = clr | (state==CLEAR). It is held high for every cycle clr is high, including a reset applied mid-operation.
- cnt_en = (state==RUN) & (pre==DIV-1) & !pause & !stop & !clr.
- A wrap event is cnt_en & cnt_tc in the same cycle; the counter rolls to 0 at that edge.
- IDLE: cnt_en=0. start=1 & stop=0: latch reps, go to CLEAR. Otherwise stay.
- CLEAR (exactly 1 cycle): cnt_clr=1, pre<=0, pass_cnt<=0, go to RUN. stop=1 goes to IDLE instead.
- RUN, transition priority:
  - stop: go to IDLE, no done pulse, pass_cnt retained.
  - else pause: go to HOLD, pre frozen.
  - else pre <= (pre==DIV-1) ? 0 : pre+1.
  - On a wrap: pass_cnt <= pass_cnt+1 (mod 2^RW). If reps_q != 0 and pass_cnt+1 == reps_q, go to DONE.
- HOLD: cnt_en=0, pre and pass_cnt frozen. stop goes to IDLE. pause=0 returns to RUN, resuming at the same prescaler phase.
- DONE (1 cycle): done=1, busy=0, cnt_en=0, go to IDLE. pass_cnt holds its final value until the next accepted start.
- start is ignored in any state other than IDLE. No queuing.
- Latency:
  - start sampled at edge k: CLEAR during cycle k+1, RUN from cycle k+2.
  - First cnt_en in the DIV-th RUN cycle.
  - With a 4-bit counter, one pass = 16 enables = 16*DIV RUN cycles.
- Continuous mode (reps=0): pass_cnt wraps 2^RW-1 to 0. done never asserts; exit only via stop or clr.
- Prescaler width = max(1, clog2(DIV)). DIV=1 means pre is always 0 and cnt_en is high every RUN cycle.

Test Plan:
- DIV=1, reps=2, start pulse. Required: cnt_clr high exactly 1 cycle, then cnt_en high 32 consecutive cycles. pass_cnt=1 after the 16th enable, pass_cnt=2 after the 32nd. done pulses for 1 cycle, then busy=0 and cnt_en=0.
- DIV=10, reps=1. Required: first cnt_en in the 10th RUN cycle, subsequent pulses every 10 clocks. 16 pulses total, done 1 cycle after the 16th pulse (160 RUN cycles).
- DIV=10, pause high for 7 cycles while pre=4. Required: paused=1, cnt_en=0, pre frozen at 4. After release, next cnt_en arrives exactly 5 RUN cycles later; pass timing is extended by 7+1 cycles.
- stop asserted in the same cycle as cnt_tc with pre==DIV-1. Required: cnt_en=0 that cycle, pass_cnt unchanged, IDLE next cycle, done never pulses.
- reps=0, DIV=1, run 17 passes. Required: pass_cnt goes 15 to 0 to 1, done stays 0. A start pulse while busy changes nothing.
- clr asserted mid-RUN for 1 cycle. Required: cnt_clr=1 and cnt_en=0 that cycle. Next cycle busy=0, pass_cnt=0, state IDLE. A following start behaves as after power-up.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// Command sequencer for an external enable-gated 4-bit counter: clears it, then
// issues prescaled enable pulses while counting completed passes (wraps).
module count_seq_ctrl #(
  parameter int DIV = 10,
  parameter int RW  = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [RW-1:0] reps,
  input  logic          cnt_tc,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          busy,
  output logic          paused,
  output logic          done,
  output logic [RW-1:0] pass_cnt
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, HOLD, DONE} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [RW-1:0] reps_reg, reps_next;
  logic [RW-1:0] pass_reg, pass_next;
  logic [RW-1:0] pass_inc;
  logic          busy_reg, paused_reg, done_reg;

  assign pass_inc = pass_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    reps_next  = reps_reg;
    pass_next  = pass_reg;
    cnt_en     = 1'b0;
    cnt_clr    = clr;
    case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          reps_next  = reps;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr    = 1'b1;
        pre_next   = '0;
        pass_next  = '0;
        state_next = stop ? IDLE : RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (pause) begin
          state_next = HOLD;
        end else begin
          cnt_en   = (pre_reg == PRE_MAX) && !clr;
          pre_next = (pre_reg == PRE_MAX) ? '0 : pre_reg + 1'b1;
          // A wrap is an enable landing on the counter's terminal count.
          if (cnt_en && cnt_tc) begin
            pass_next = pass_inc;
            if ((reps_reg != '0) && (pass_inc == reps_reg)) begin
              state_next = DONE;
            end
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg  <= IDLE;
      pre_reg    <= '0;
      reps_reg   <= '0;
      pass_reg   <= '0;
      busy_reg   <= 1'b0;
      paused_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pre_reg    <= pre_next;
      reps_reg   <= reps_next;
      pass_reg   <= pass_next;
      busy_reg   <= (state_next == CLEAR) || (state_next == RUN) || (state_next == HOLD);
      paused_reg <= (state_next == HOLD);
      done_reg   <= (state_next == DONE);
    end
  end

  assign busy     = busy_reg;
  assign paused   = paused_reg;
  assign done     = done_reg;
  assign pass_cnt = pass_reg;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: two instances (DIV=1, DIV=10) share stimulus, each
// drives its own 4-bit counter and is checked every cycle against a timing model.
`timescale 1ns/1ps
module tb_count_seq_ctrl;

  localparam int RW = 4;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_HOLD = 3, M_DONE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr, start, stop, pause;
  logic [RW-1:0] reps;
  logic [1:0]    en_v, clr_v, busy_v, paused_v, done_v, tc_v;
  logic [1:0][RW-1:0] pc_v, cnt_v;

  int divs [2] = '{1, 10};
  int errors = 0;
  int checks = 0;
  int txn = 0;

  count_seq_ctrl #(.DIV(1), .RW(RW)) dut_a (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause), .reps(reps),
    .cnt_tc(tc_v[0]), .cnt_en(en_v[0]), .cnt_clr(clr_v[0]), .busy(busy_v[0]),
    .paused(paused_v[0]), .done(done_v[0]), .pass_cnt(pc_v[0]));

  count_seq_ctrl #(.DIV(10), .RW(RW)) dut_b (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause), .reps(reps),
    .cnt_tc(tc_v[1]), .cnt_en(en_v[1]), .cnt_clr(clr_v[1]), .busy(busy_v[1]),
    .paused(paused_v[1]), .done(done_v[1]), .pass_cnt(pc_v[1]));

  // External counters driven by each sequencer
  assign tc_v[0] = (cnt_v[0] == 4'hF);
  assign tc_v[1] = (cnt_v[1] == 4'hF);
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr_v[i]) cnt_v[i] <= '0;
      else if (en_v[i]) cnt_v[i] <= cnt_v[i] + 4'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Timing model: mode, count of unfrozen RUN cycles, enables since last clear
  int         m_mode [2];
  int         m_k    [2];
  int         m_cnt  [2];
  logic [3:0] m_pass [2];
  logic [3:0] m_reps [2];
  bit         e_en   [2];
  bit         e_tc   [2];
  bit         model_on = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      e_en[i] = (m_mode[i] == M_RUN) && ((m_k[i] % divs[i]) == divs[i] - 1)
                && !pause && !stop && !clr;
      e_tc[i] = (m_cnt[i] == 15);
      if (model_on) begin
        chk($sformatf("dut%0d.cnt_en", i),  32'(en_v[i]),  32'(e_en[i]));
        chk($sformatf("dut%0d.cnt_clr", i), 32'(clr_v[i]), 32'(clr || (m_mode[i] == M_CLEAR)));
        chk($sformatf("dut%0d.busy", i),    32'(busy_v[i]),
            32'((m_mode[i] == M_CLEAR) || (m_mode[i] == M_RUN) || (m_mode[i] == M_HOLD)));
        chk($sformatf("dut%0d.paused", i),  32'(paused_v[i]), 32'(m_mode[i] == M_HOLD));
        chk($sformatf("dut%0d.done", i),    32'(done_v[i]),   32'(m_mode[i] == M_DONE));
        chk($sformatf("dut%0d.pass_cnt", i), 32'(pc_v[i]),    32'(m_pass[i]));
      end
      if (clr) begin
        m_mode[i] = M_IDLE; m_pass[i] = '0; m_reps[i] = '0; m_cnt[i] = 0; m_k[i] = 0;
      end else begin
        case (m_mode[i])
          M_IDLE: if (start && !stop) begin
            m_reps[i] = reps;
            m_mode[i] = M_CLEAR;
            if (i == 1) begin
              txn++;
              $display("txn %0d: start accepted reps=%0d at %0t", txn, reps, $time);
            end
          end
          M_CLEAR: begin
            m_cnt[i] = 0; m_k[i] = 0; m_pass[i] = '0;
            m_mode[i] = stop ? M_IDLE : M_RUN;
          end
          M_RUN: begin
            if (stop) m_mode[i] = M_IDLE;
            else if (pause) m_mode[i] = M_HOLD;
            else begin
              if (e_en[i]) begin
                m_cnt[i] = (m_cnt[i] + 1) % 16;
                if (e_tc[i]) begin
                  m_pass[i] = m_pass[i] + 4'd1;
                  if ((m_reps[i] != 0) && (m_pass[i] == m_reps[i])) m_mode[i] = M_DONE;
                end
              end
              m_k[i]++;
            end
          end
          M_HOLD: begin
            if (stop) m_mode[i] = M_IDLE;
            else if (!pause) m_mode[i] = M_RUN;
          end
          default: m_mode[i] = M_IDLE;
        endcase
      end
    end
    if (clr) model_on = 1'b1;
  end

  initial begin
    int en_a_n, en_b_n, clr_a_n, done_a_c, done_b_c, first_en_b, second_en_b;
    int pass18, p242, p258, p274, done_seen;
    clr = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; reps = '0;
    step(); step();
    clr = 1'b0;
    step();

    // Two passes: DIV=1 gives 32 back-to-back enables; DIV=10 one per 10 clocks
    en_a_n = 0; en_b_n = 0; clr_a_n = 0; done_a_c = -1; done_b_c = -1; first_en_b = -1; pass18 = -1;
    reps = 4'd2; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 330; c++) begin
      @(negedge clk);
      if (en_v[0]) en_a_n++;
      if (en_v[1]) en_b_n++;
      if (clr_v[0]) clr_a_n++;
      if (done_v[0] && done_a_c < 0) done_a_c = c;
      if (done_v[1] && done_b_c < 0) done_b_c = c;
      if (en_v[1] && first_en_b < 0) first_en_b = c;
      if (c == 18) pass18 = int'(pc_v[0]);
      step();
    end
    $display("test two_passes complete");
    chk("t1.a_en_count", 32'(en_a_n), 32);
    chk("t1.a_clr_count", 32'(clr_a_n), 1);
    chk("t1.a_done_cycle", 32'(done_a_c), 34);
    chk("t1.a_pass_after_16", 32'(pass18), 1);
    chk("t1.a_pass_final", 32'(pc_v[0]), 2);
    chk("t1.b_first_en", 32'(first_en_b), 11);
    chk("t1.b_en_count", 32'(en_b_n), 32);
    chk("t1.b_done_cycle", 32'(done_b_c), 322);

    // Pause for 7 cycles while the DIV=10 prescaler sits at 4
    first_en_b = -1; second_en_b = -1;
    reps = 4'd1; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      pause = (c >= 6) && (c <= 12);
      @(negedge clk);
      if (c == 7)  chk("t2.b_paused_c7", 32'(paused_v[1]), 1);
      if (c == 13) chk("t2.b_paused_c13", 32'(paused_v[1]), 1);
      if (c == 14) chk("t2.b_paused_c14", 32'(paused_v[1]), 0);
      if (en_v[1] && first_en_b >= 0 && second_en_b < 0) second_en_b = c;
      if (en_v[1] && first_en_b < 0) first_en_b = c;
      step();
    end
    pause = 1'b0;
    $display("test pause complete");
    chk("t2.b_first_en", 32'(first_en_b), 19);
    chk("t2.b_second_en", 32'(second_en_b), 29);
    stop = 1'b1; step(); stop = 1'b0; step();

    // Abort on the cycle the final enable would wrap the counter
    done_seen = 0;
    reps = 4'd1; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 170; c++) begin
      stop = (c == 161);
      @(negedge clk);
      if (c >= 20 && done_v[1]) done_seen = 1;
      if (c == 161) begin
        chk("t3.b_tc_at_stop", 32'(tc_v[1]), 1);
        chk("t3.b_en_at_stop", 32'(en_v[1]), 0);
      end
      if (c == 162) begin
        chk("t3.b_busy_after", 32'(busy_v[1]), 0);
        chk("t3.b_pass_after", 32'(pc_v[1]), 0);
      end
      step();
    end
    stop = 1'b0;
    $display("test stop_at_tc complete");
    chk("t3.b_done_seen", 32'(done_seen), 0);

    // Continuous mode for 17 passes, ignored start, then reset mid-run
    done_seen = 0; p242 = -1; p258 = -1; p274 = -1;
    reps = 4'd0; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 290; c++) begin
      start = (c == 100);
      clr = (c == 280);
      @(negedge clk);
      if (done_v[0]) done_seen = 1;
      if (c == 242) p242 = int'(pc_v[0]);
      if (c == 258) p258 = int'(pc_v[0]);
      if (c == 274) p274 = int'(pc_v[0]);
      if (c == 280) begin
        chk("t4.a_clr_mid", 32'(clr_v[0]), 1);
        chk("t4.a_en_mid", 32'(en_v[0]), 0);
      end
      if (c == 281) begin
        chk("t4.a_busy_after_clr", 32'(busy_v[0]), 0);
        chk("t4.a_pass_after_clr", 32'(pc_v[0]), 0);
      end
      step();
    end
    start = 1'b0; clr = 1'b0;
    $display("test continuous complete");
    chk("t4.a_pass_15", 32'(p242), 15);
    chk("t4.a_pass_0", 32'(p258), 0);
    chk("t4.a_pass_1", 32'(p274), 1);
    chk("t4.a_done_seen", 32'(done_seen), 0);

    // Start after the mid-run reset behaves as from power-up
    done_a_c = -1;
    reps = 4'd1; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done_v[0] && done_a_c < 0) done_a_c = c;
      step();
    end
    chk("t5.a_done_cycle", 32'(done_a_c), 18);
    stop = 1'b1; step(); stop = 1'b0;

    // Randomized commands, checked every cycle by the model
    for (int n = 0; n < 12000; n++) begin
      start = ($urandom_range(0, 29) == 0);
      reps  = 4'($urandom_range(0, 3));
      stop  = ($urandom_range(0, 499) == 0);
      clr   = ($urandom_range(0, 1499) == 0);
      if (pause) pause = ($urandom_range(0, 7) != 0);
      else       pause = ($urandom_range(0, 149) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0; clr = 1'b0; pause = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
